// File: rtl/dptrain.sv
// DisplayPort single-lane link-training sequencer: owns the PHY control word and
// drives clock recovery / channel equalization through DPCD accesses on an AUX master.
module dptrain #(
    parameter int unsigned RST_CYC   = 256,
    parameter int unsigned WAIT_CYC  = 4096,
    parameter int unsigned MAX_TRIES = 5,
    parameter logic [7:0]  LINK_BW   = 8'h0A
) (
    input  logic        usrclk,
    input  logic        reset,
    input  logic        start,
    output logic        phy_reset,
    output logic [1:0]  phy_mode,
    output logic        aux_req,
    output logic        aux_wr,
    output logic [19:0] aux_addr,
    output logic [7:0]  aux_wdata,
    input  logic        aux_ack,
    input  logic        aux_err,
    input  logic [7:0]  aux_rdata,
    output logic        busy,
    output logic        done,
    output logic        fail
);

    typedef enum logic [3:0] {
        S_IDLE, S_PHYRST, S_CFG0, S_CFG1,
        S_CRWR, S_CRWAIT, S_CRRD,
        S_EQWR, S_EQWAIT, S_EQRD,
        S_END, S_FAILWR, S_FAIL, S_RUN
    } state_t;

    localparam logic [15:0] RST_LAST  = (RST_CYC == 0)  ? 16'd0 : 16'(RST_CYC - 1);
    localparam logic [15:0] WAIT_LAST = (WAIT_CYC == 0) ? 16'd0 : 16'(WAIT_CYC - 1);

    state_t      state_q, state_d;
    logic        prst_q, prst_d;
    logic [1:0]  mode_q, mode_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic [15:0] wait_q, wait_d;
    logic [2:0]  try_q, try_d;
    logic        busy_q, done_q, fail_q;

    logic        acked, in_cr, pass, iss, iss_wr;
    logic [19:0] iss_addr;
    logic [7:0]  iss_data;
    logic [2:0]  try_inc;
    logic        unused_rdata;

    assign unused_rdata = ^aux_rdata[7:3];

    always_comb begin
        state_d   = state_q;
        prst_d    = prst_q;
        mode_d    = mode_q;
        req_d     = req_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rst_cnt_d = rst_cnt_q;
        wait_d    = wait_q;
        try_d     = try_q;
        iss       = 1'b0;
        iss_wr    = 1'b1;
        iss_addr  = 20'h00102;
        iss_data  = 8'h00;
        acked     = req_q && aux_ack;
        in_cr     = (state_q == S_CRRD);
        pass      = in_cr ? aux_rdata[0] : (aux_rdata[2:0] == 3'b111);
        try_inc   = (try_q == 3'd7) ? try_q : try_q + 3'd1;

        case (state_q)
            S_IDLE, S_RUN, S_FAIL: begin
                if (start) begin
                    state_d   = S_PHYRST;
                    prst_d    = 1'b1;
                    mode_d    = 2'd0;
                    rst_cnt_d = '0;
                end
            end
            S_PHYRST: begin
                rst_cnt_d = rst_cnt_q + 16'd1;
                if (rst_cnt_q == RST_LAST) begin
                    prst_d  = 1'b0;
                    state_d = S_CFG0;
                end
            end
            S_CFG0, S_CFG1: begin
                iss      = !req_q;
                iss_addr = (state_q == S_CFG0) ? 20'h00100 : 20'h00101;
                iss_data = (state_q == S_CFG0) ? LINK_BW : 8'h81;
                if (acked) begin
                    req_d = 1'b0;
                    if (aux_err)                 state_d = S_FAILWR;
                    else if (state_q == S_CFG0)  state_d = S_CFG1;
                    else begin
                        state_d = S_CRWR;
                        mode_d  = 2'd2;
                        try_d   = '0;
                    end
                end
            end
            // Pattern write: a write error is not fatal, the status reads decide.
            S_CRWR, S_EQWR: begin
                iss      = !req_q;
                iss_data = (state_q == S_CRWR) ? 8'h21 : 8'h22;
                if (acked) begin
                    req_d   = 1'b0;
                    wait_d  = '0;
                    state_d = (state_q == S_CRWR) ? S_CRWAIT : S_EQWAIT;
                end
            end
            S_CRWAIT, S_EQWAIT: begin
                wait_d = wait_q + 16'd1;
                if (wait_q == WAIT_LAST) begin
                    iss      = 1'b1;
                    iss_wr   = 1'b0;
                    iss_addr = 20'h00202;
                    state_d  = (state_q == S_CRWAIT) ? S_CRRD : S_EQRD;
                end
            end
            S_CRRD, S_EQRD: begin
                if (acked) begin
                    req_d = 1'b0;
                    if (!aux_err && pass) begin
                        if (in_cr) begin
                            state_d = S_EQWR;
                            mode_d  = 2'd3;
                            try_d   = '0;
                        end else begin
                            state_d = S_END;
                        end
                    end else begin
                        try_d  = try_inc;
                        wait_d = '0;
                        if (32'(try_inc) >= MAX_TRIES) state_d = S_FAILWR;
                        else state_d = in_cr ? S_CRWAIT : S_EQWAIT;
                    end
                end
            end
            S_END: begin
                iss = !req_q;
                if (acked) begin
                    req_d   = 1'b0;
                    mode_d  = 2'd1;
                    state_d = S_RUN;
                end
            end
            S_FAILWR: begin
                iss = !req_q;
                if (acked) begin
                    req_d   = 1'b0;
                    mode_d  = 2'd0;
                    state_d = S_FAIL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (iss) begin
            req_d   = 1'b1;
            wr_d    = iss_wr;
            addr_d  = iss_addr;
            wdata_d = iss_data;
        end
    end

    always_ff @(posedge usrclk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            prst_q    <= 1'b1;
            mode_q    <= 2'd0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rst_cnt_q <= '0;
            wait_q    <= '0;
            try_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prst_q    <= prst_d;
            mode_q    <= mode_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rst_cnt_q <= rst_cnt_d;
            wait_q    <= wait_d;
            try_q     <= try_d;
            busy_q    <= !(state_d inside {S_IDLE, S_RUN, S_FAIL});
            done_q    <= (state_d == S_RUN);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign phy_reset = prst_q;
    assign phy_mode  = mode_q;
    assign aux_req   = req_q;
    assign aux_wr    = wr_q;
    assign aux_addr  = addr_q;
    assign aux_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_dptrain.sv
// Randomized-latency AUX responder plus a transaction-level reference of the
// training sequence; compares DPCD traffic, PHY mode history and final status.
module tb_dptrain;
    localparam int          RST_CYC   = 8;
    localparam int          WAIT_CYC  = 20;
    localparam int          MAX_TRIES = 5;
    localparam logic [7:0]  LINK_BW   = 8'h0A;
    localparam int          LIMIT     = 3000;

    logic        usrclk = 1'b0;
    logic        reset  = 1'b1;
    logic        start  = 1'b0;
    logic        aux_ack = 1'b0, aux_err = 1'b0;
    logic [7:0]  aux_rdata = 8'h00;
    logic        phy_reset, aux_req, aux_wr, busy, done, fail;
    logic [1:0]  phy_mode;
    logic [19:0] aux_addr;
    logic [7:0]  aux_wdata;

    always #5 usrclk = ~usrclk;

    dptrain #(.RST_CYC(RST_CYC), .WAIT_CYC(WAIT_CYC), .MAX_TRIES(MAX_TRIES), .LINK_BW(LINK_BW)) dut (
        .usrclk(usrclk), .reset(reset), .start(start),
        .phy_reset(phy_reset), .phy_mode(phy_mode),
        .aux_req(aux_req), .aux_wr(aux_wr), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_err(aux_err), .aux_rdata(aux_rdata),
        .busy(busy), .done(done), .fail(fail)
    );

    typedef struct { logic [28:0] t; int rise; int ack; } tx_t;

    tx_t         log_q[$];
    logic [28:0] exp_q[$];
    int          mode_q[$], mode_exp[$];
    logic [7:0]  rd_script[$], rd_q[$];
    bit          exp_ok;
    int          nvec = 0, nerr = 0;
    int          cyc = 0, last_ack = -100, cur_rise = 0, proto_bad = 0, budget = -1, lat = 0;
    bit          pend = 0, req_prev = 0, stale = 0;
    logic [28:0] hold = '0;
    logic [19:0] err_addr = 20'hFFFFF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] wtx(input logic [19:0] a, input logic [7:0] d);
        return {1'b1, a, d};
    endfunction

    // One clock: monitors first (values settled after the edge), then the AUX responder.
    task automatic tick();
        bit ack_prev;
        @(negedge usrclk);
        cyc++;
        ack_prev = aux_ack;
        if (aux_req === 1'b1) begin
            if (!req_prev) begin
                cur_rise = cyc;
                if (cyc - last_ack < 2) proto_bad++;
                hold = {aux_wr, aux_addr, aux_wdata};
            end else if (ack_prev) begin
                proto_bad++;
            end else if ({aux_wr, aux_addr, aux_wdata} !== hold) begin
                proto_bad++;
            end
        end
        req_prev = (aux_req === 1'b1);
        if (mode_q.size() > 0 && int'(phy_mode) != mode_q[$]) mode_q.push_back(int'(phy_mode));

        if (ack_prev) begin
            aux_ack = 1'b0; aux_err = 1'b0; aux_rdata = 8'h00;
        end else if (stale) begin
            aux_ack = 1'b1; stale = 0;
        end else if (aux_req === 1'b1 && budget != 0) begin
            if (!pend) begin pend = 1; lat = int'($urandom_range(0, 3)); end
            if (lat == 0) begin
                pend = 0;
                aux_ack = 1'b1;
                aux_err = aux_wr && (aux_addr == err_addr);
                if (!aux_wr) aux_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                log_q.push_back('{t: aux_wr ? {1'b1, aux_addr, aux_wdata} : {1'b0, aux_addr, 8'h00},
                                  rise: cur_rise, ack: cyc});
                last_ack = cyc;
                if (budget > 0) budget--;
            end else lat--;
        end else pend = 0;
    endtask

    // Expected DPCD traffic from the training rules, given the read-data script.
    task automatic model(input int cfg_err);
        int  k = 0;
        bit  passed;
        logic [7:0] v;
        exp_q.delete(); mode_exp = {0};
        exp_q.push_back(wtx(20'h00100, LINK_BW));
        if (cfg_err == 0) begin exp_q.push_back(wtx(20'h00102, 8'h00)); exp_ok = 0; return; end
        exp_q.push_back(wtx(20'h00101, 8'h81));
        if (cfg_err == 1) begin exp_q.push_back(wtx(20'h00102, 8'h00)); exp_ok = 0; return; end
        for (int ph = 0; ph < 2; ph++) begin
            mode_exp.push_back(ph == 0 ? 2 : 3);
            exp_q.push_back(wtx(20'h00102, ph == 0 ? 8'h21 : 8'h22));
            passed = 0;
            for (int t = 0; t < MAX_TRIES && !passed; t++) begin
                v = (k < rd_script.size()) ? rd_script[k] : 8'h00;
                k++;
                exp_q.push_back({1'b0, 20'h00202, 8'h00});
                passed = (ph == 0) ? v[0] : (v[2:0] == 3'b111);
            end
            if (!passed) begin
                exp_q.push_back(wtx(20'h00102, 8'h00));
                mode_exp.push_back(0);
                exp_ok = 0;
                return;
            end
        end
        exp_q.push_back(wtx(20'h00102, 8'h00));
        mode_exp.push_back(1);
        exp_ok = 1;
    endtask

    function automatic logic [31:0] pack_modes(input int q[$]);
        logic [31:0] w = 32'd1;
        foreach (q[i]) w = {w[27:0], 4'(q[i])};
        return w;
    endfunction

    task automatic run_case(input string tag, input int cfg_err, input bit poke, input bit chk_rst);
        int n;
        int bad = 0;
        bit poked = 0;
        model(cfg_err);
        rd_q = rd_script;
        err_addr = (cfg_err == 0) ? 20'h00100 : (cfg_err == 1) ? 20'h00101 : 20'hFFFFF;
        log_q.delete(); mode_q = {0}; proto_bad = 0;
        start = 1'b1; tick(); start = 1'b0;
        if (chk_rst) begin
            chk({tag, ":done_drop"}, 32'(done), 32'd0);
            n = 0;
            while (phy_reset && n < LIMIT) begin n++; tick(); end
            chk({tag, ":rst_len"}, 32'(n), 32'(RST_CYC));
        end
        n = 0;
        while (!(done || fail) && n < LIMIT) begin
            start = poke && !poked && phy_mode == 2'd2 && busy;
            if (start) poked = 1;
            tick(); n++;
        end
        start = 1'b0;
        chk({tag, ":timeout"}, 32'(n < LIMIT), 32'd1);
        chk({tag, ":ntx"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s:tx%0d", tag, i), 32'(log_q[i].t), 32'(exp_q[i]));
        for (int i = 1; i < log_q.size(); i++)
            if (!log_q[i].t[28] && log_q[i].rise - log_q[i-1].ack != WAIT_CYC + 1) bad++;
        chk({tag, ":read_spacing"}, 32'(bad), 32'd0);
        chk({tag, ":proto"}, 32'(proto_bad), 32'd0);
        chk({tag, ":modes"}, pack_modes(mode_q), pack_modes(mode_exp));
        chk({tag, ":done"}, 32'(done), 32'(exp_ok));
        chk({tag, ":fail"}, 32'(fail), 32'(!exp_ok));
        chk({tag, ":busy"}, 32'(busy), 32'd0);
        chk({tag, ":phy_mode"}, 32'(phy_mode), exp_ok ? 32'd1 : 32'd0);
        chk({tag, ":phy_reset"}, 32'(phy_reset), 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] v;
        repeat (3) tick();
        chk("rst:phy_reset", 32'(phy_reset), 32'd1);
        chk("rst:phy_mode", 32'(phy_mode), 32'd0);
        chk("rst:aux_req", 32'(aux_req), 32'd0);
        chk("rst:aux_wr", 32'(aux_wr), 32'd0);
        chk("rst:aux_addr", 32'(aux_addr), 32'd0);
        chk("rst:aux_wdata", 32'(aux_wdata), 32'd0);
        chk("rst:flags", {29'd0, busy, done, fail}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle:phy_reset", 32'(phy_reset), 32'd1);

        rd_script = {8'h01, 8'h07};                 run_case("happy", 2, 0, 0);
        rd_script = {};                             run_case("cr_exhaust", 2, 0, 0);
        rd_script = {8'h01, 8'h03, 8'h03, 8'h07};   run_case("eq_retry", 2, 0, 0);
        rd_script = {};                             run_case("cfg_err", 1, 0, 0);
        rd_script = {8'h00, 8'h01, 8'h07};          run_case("start_in_cr", 2, 1, 0);
        rd_script = {8'h01, 8'h07};                 run_case("restart_run", 2, 0, 1);

        // Reset while the EQ status read is outstanding, then a stale ack.
        rd_script = {8'h01}; rd_q = rd_script; err_addr = 20'hFFFFF; budget = 5;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(aux_req && aux_addr == 20'h00202 && phy_mode == 2'd3) && n < LIMIT) begin tick(); n++; end
        chk("eqrst:reach", 32'(n < LIMIT), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("eqrst:aux_req", 32'(aux_req), 32'd0);
        chk("eqrst:phy_reset", 32'(phy_reset), 32'd1);
        chk("eqrst:phy_mode", 32'(phy_mode), 32'd0);
        budget = -1; stale = 1;
        repeat (4) tick();
        chk("eqrst:stale_idle", {27'd0, aux_req, busy, done, fail, phy_reset}, 32'd1);
        chk("eqrst:stale_mode", 32'(phy_mode), 32'd0);

        for (int r = 0; r < 6; r++) begin
            rd_script.delete();
            for (int j = 0; j < 12; j++) begin
                case ($urandom_range(0, 4))
                    0: v = 8'h00;
                    1: v = 8'h01;
                    2: v = 8'h03;
                    3: v = 8'h07;
                    default: v = 8'($urandom);
                endcase
                rd_script.push_back(v);
            end
            run_case($sformatf("rand%0d", r), ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 1)) : 2, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dptrain.md
# dptrain

DisplayPort link-training sequencer for the single-lane main-link transmitter. It owns the PHY control word: it holds the transceiver in reset, selects the idle, TPS1, TPS2 and video data modes, and walks the sink through clock recovery and channel equalization using DPCD accesses over an external AUX master. On success it leaves the PHY in data mode and asserts `done`; on exhausted retries it idles the link and asserts `fail`.

## Interface
Parameters:
- `RST_CYC`, default 256: cycles `phy_reset` is held in the PHYRST state.
- `WAIT_CYC`, default 4096: cycles spent in a training pattern before each status read.
- `MAX_TRIES`, default 5: status reads allowed per training phase before FAIL.
- `LINK_BW`, default 8'h0A: value written to DPCD 0x00100 (LINK_BW_SET).

Ports:
- `usrclk`, in, 1: PHY user clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle pulse that begins or restarts training.
- `phy_reset`, out, 1: transceiver reset (PHY control bit 31).
- `phy_mode`, out, 2: PHY mode select (PHY control bits [1:0]).
  - 0: idle.
  - 1: data.
  - 2: TPS1 (D10.2).
  - 3: TPS2.
- `aux_req`, out, 1: AUX transaction request.
- `aux_wr`, out, 1: AUX direction. 1 = write, 0 = read.
- `aux_addr`, out, 20: DPCD address.
- `aux_wdata`, out, 8: write data.
- `aux_ack`, in, 1: one-cycle completion strobe from the AUX master.
- `aux_err`, in, 1: qualifies `aux_ack`. NACK or timeout.
- `aux_rdata`, in, 8: read data, valid with `aux_ack`.
- `busy`, out, 1: high in every state except IDLE, RUN and FAIL.
- `done`, out, 1: level, high in RUN.
- `fail`, out, 1: level, high in FAIL.

## Operation
- **Reset values.**
  - `phy_reset` = 1; `phy_mode` = 0.
  - `aux_req`, `aux_wr` = 0; `aux_addr`, `aux_wdata` = 0.
  - `busy`, `done`, `fail` = 0.
  - State = IDLE; all counters = 0.
- **IDLE.** `phy_reset` = 1, `phy_mode` = 0. `start` moves to PHYRST.
- **PHYRST.** Hold `phy_reset` = 1 for `RST_CYC` cycles, then release it (0 from here on) and go to CFG.
- **CFG.** Two AUX writes:
  - 0x00100 ← `LINK_BW`.
  - 0x00101 ← 8'h81 (enhanced framing, 1 lane).
  - Any `aux_err` goes to FAIL.
- **CR (clock recovery).**
  - On entry: `phy_mode` = 2, retry count = 0.
  - Write 0x00102 ← 8'h21, then wait `WAIT_CYC` cycles, then read 0x00202.
  - If `aux_rdata[0]` = 1 (CR_DONE), go to EQ.
  - Otherwise, or on `aux_err`, increment the retry count:
    - if it reaches `MAX_TRIES`, go to FAIL;
    - else repeat from the wait (the pattern write is not reissued).
- **EQ (channel equalization).**
  - On entry: `phy_mode` = 3, retry count = 0.
  - Write 0x00102 ← 8'h22, then follow the same wait/read/retry loop as CR.
  - Pass condition is `aux_rdata[2:0]` = 3'b111. On pass, go to END.
- **END.** Write 0x00102 ← 8'h00. When the ack arrives, set `phy_mode` = 1 and go to RUN. `aux_err` here is ignored.
- **RUN.** `done` = 1, `phy_mode` = 1.
- **FAIL.**
  - Entered from CFG, CR or EQ.
  - If a write of 0x00102 ← 8'h00 has not already been attempted, issue it; ignore its result.
  - Then `phy_mode` = 0 and `fail` = 1.
- **`start` handling.**
  - In RUN or FAIL, `start` restarts at PHYRST and clears `done`/`fail` in that cycle.
  - While `busy`, `start` is ignored.
- **AUX handshake.**
  - `aux_req` rises with `aux_addr`, `aux_wr` and `aux_wdata` already stable.
  - All four hold until the cycle `aux_ack` = 1 is sampled.
  - `aux_req` is 0 in the following cycle. At most one request is outstanding.
  - `aux_ack` while `aux_req` = 0 is ignored.
- **Widths.** Wait counter 16 bits; retry counter 3 bits, saturating; reset counter 16 bits.

## Timing
- All outputs are registered.
- `phy_mode` changes in the first cycle of the new state. The TPS write is issued after `phy_mode` is updated, never before.
- The wait counter starts in the cycle after the ack of the pattern write (or the failed status read).
  - The status-read `aux_req` rises exactly `WAIT_CYC` cycles later.
- Minimum gap between `aux_ack` and the next `aux_req` is 1 cycle (the idle cycle).
- `reset` has priority over all events.
  - Mid-transaction `reset` drops `aux_req` the next cycle and abandons the transfer.
  - A late `aux_ack` after reset is ignored.
- `start` and `aux_ack` in the same cycle: `start` is ignored if `busy`.

## Test plan
1. **Happy path.**
   - Stimulus: `start`; AUX model acks every access with no error; 0x00202 reads return 8'h01 in CR and 8'h07 in EQ.
   - Required: write sequence 0x100=0x0A, 0x101=0x81, 0x102=0x21, 0x102=0x22, 0x102=0x00; `phy_mode` sequence 0→2→3→1; `done` = 1, `busy` = 0.
2. **CR exhaustion.**
   - Stimulus: 0x00202 always reads 8'h00.
   - Required: exactly 5 reads spaced `WAIT_CYC`+gap apart; 0x102=0x00 written; `fail` = 1, `phy_mode` = 0.
3. **EQ retry recovery.**
   - Stimulus: EQ reads return 8'h03, then 8'h03, then 8'h07.
   - Required: 3 EQ reads with no 0x102=0x22 reissue; ends in RUN.
4. **CFG error.**
   - Stimulus: `aux_err` on the 0x00101 write.
   - Required: FAIL reached; `phy_mode` never leaves 0; no 0x102=0x21 write.
5. **Reset mid-EQ.**
   - Stimulus: `reset` while `aux_req` = 1 during the EQ read.
   - Required: next cycle `aux_req` = 0, `phy_reset` = 1, `phy_mode` = 0; state IDLE; a stale `aux_ack` causes no transition.
6. **Start handling.**
   - Stimulus: `start` pulse during CR, then `start` pulse in RUN.
   - Required: the pulse during CR is ignored; the pulse in RUN drops `done`, asserts `phy_reset` for `RST_CYC` cycles, and retrains.
